// File: rtl/fifo_multicanal.sv
// rtl/fifo_multicanal.sv - bank of independent synchronous FIFOs with registered read data
//
// Parameters: WIDTH (data bits), DEPTH (words per channel, any value >= 2),
//             CHANNELS (independent FIFOs), AF_LEVEL (almost-full threshold),
//             CNT_W (occupancy width, derived from DEPTH; leave at default).
// Build option: FIFO_OVERWRITE_EN - when defined, a push into a full channel
//             without a simultaneous pop replaces the oldest word instead of
//             being dropped.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   push_i, pop_i   per-channel write / read strobes
//   dato_i          packed write data, channel c at [c*WIDTH +: WIDTH]
//   clr_err_i       clears all sticky error flags (a same-cycle new error wins)
//   dato_o          packed registered read data, updated only on accepted pops
//   full_o, empty_o, almost_full_o, count_o   per-channel status from registered count
//   overflow_o, underflow_o                    per-channel sticky error flags
module fifo_multicanal #(
    parameter int WIDTH    = 16,
    parameter int DEPTH    = 8,
    parameter int CHANNELS = 2,
    parameter int AF_LEVEL = 6,
    parameter int CNT_W    = $clog2(DEPTH + 1)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CHANNELS-1:0]       push_i,
    input  logic [CHANNELS-1:0]       pop_i,
    input  logic [CHANNELS*WIDTH-1:0] dato_i,
    input  logic                      clr_err_i,
    output logic [CHANNELS*WIDTH-1:0] dato_o,
    output logic [CHANNELS-1:0]       full_o,
    output logic [CHANNELS-1:0]       empty_o,
    output logic [CHANNELS-1:0]       almost_full_o,
    output logic [CHANNELS*CNT_W-1:0] count_o,
    output logic [CHANNELS-1:0]       overflow_o,
    output logic [CHANNELS-1:0]       underflow_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        logic [WIDTH-1:0] mem [DEPTH];
        logic [PTR_W-1:0] wr_ptr;
        logic [PTR_W-1:0] rd_ptr;
        logic [CNT_W-1:0] cnt;
        logic [WIDTH-1:0] rd_q;
        logic             ov_q;
        logic             un_q;

        logic [WIDTH-1:0] din;
        logic             is_full;
        logic             is_empty;
        logic             push_ok;
        logic             pop_ok;
        logic             ov_hit;
        logic             un_hit;
        logic             wr_en;
        logic             adv_rd;

        assign din = dato_i[c*WIDTH +: WIDTH];

        always_comb begin
            is_full  = (cnt == CNT_W'(DEPTH));
            is_empty = (cnt == '0);
            pop_ok   = pop_i[c] & ~is_empty;
            // A pop on a full channel frees the slot the push lands in.
            push_ok  = push_i[c] & (~is_full | pop_i[c]);
            ov_hit   = push_i[c] & is_full & ~pop_i[c];
            un_hit   = pop_i[c] & is_empty;
`ifdef FIFO_OVERWRITE_EN
            // Overwrite: write over the oldest slot and step past it, so the
            // occupancy stays at DEPTH while the read pointer follows along.
            wr_en    = push_ok | ov_hit;
            adv_rd   = pop_ok | ov_hit;
`else
            wr_en    = push_ok;
            adv_rd   = pop_ok;
`endif
        end

        // Storage is deliberately left out of reset.
        always_ff @(posedge clk) begin
            if (wr_en) begin
                mem[wr_ptr] <= din;
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                cnt    <= '0;
                rd_q   <= '0;
                ov_q   <= 1'b0;
                un_q   <= 1'b0;
            end else begin
                if (wr_en) begin
                    wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
                end
                if (adv_rd) begin
                    rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
                end
                if (pop_ok) begin
                    rd_q <= mem[rd_ptr];
                end
                if (push_ok && !pop_ok) begin
                    cnt <= cnt + 1'b1;
                end else if (pop_ok && !push_ok) begin
                    cnt <= cnt - 1'b1;
                end
                // Clear drops old history; an error in the same cycle still sets.
                ov_q <= clr_err_i ? ov_hit : (ov_q | ov_hit);
                un_q <= clr_err_i ? un_hit : (un_q | un_hit);
            end
        end

        assign dato_o[c*WIDTH +: WIDTH]  = rd_q;
        assign count_o[c*CNT_W +: CNT_W] = cnt;
        assign full_o[c]                 = (cnt == CNT_W'(DEPTH));
        assign empty_o[c]                = (cnt == '0);
        assign almost_full_o[c]          = (cnt >= CNT_W'(AF_LEVEL));
        assign overflow_o[c]             = ov_q;
        assign underflow_o[c]            = un_q;
    end

endmodule

// File: tb/tb_fifo_multicanal.sv
// tb/tb_fifo_multicanal.sv - self-checking bench for fifo_multicanal with a queue reference model
module tb_fifo_multicanal;

    localparam int WIDTH    = 16;
    localparam int DEPTH    = 8;
    localparam int CHANNELS = 2;
    localparam int AF_LEVEL = 6;
    localparam int CNT_W    = 4;

    logic                      clk = 1'b0;
    logic                      rst_n;
    logic [CHANNELS-1:0]       push_i;
    logic [CHANNELS-1:0]       pop_i;
    logic [CHANNELS*WIDTH-1:0] dato_i;
    logic                      clr_err_i;
    logic [CHANNELS*WIDTH-1:0] dato_o;
    logic [CHANNELS-1:0]       full_o;
    logic [CHANNELS-1:0]       empty_o;
    logic [CHANNELS-1:0]       almost_full_o;
    logic [CHANNELS*CNT_W-1:0] count_o;
    logic [CHANNELS-1:0]       overflow_o;
    logic [CHANNELS-1:0]       underflow_o;

    int errors = 0;
    int checks = 0;

    // Reference model: one queue of words per channel plus expected read lane and sticky flags.
    logic [WIDTH-1:0] mq [CHANNELS][$];
    logic [WIDTH-1:0] m_dato [CHANNELS];
    logic             m_ov   [CHANNELS];
    logic             m_un   [CHANNELS];

    fifo_multicanal #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .CHANNELS(CHANNELS), .AF_LEVEL(AF_LEVEL)
    ) dut (
        .clk(clk), .rst_n(rst_n), .push_i(push_i), .pop_i(pop_i), .dato_i(dato_i),
        .clr_err_i(clr_err_i), .dato_o(dato_o), .full_o(full_o), .empty_o(empty_o),
        .almost_full_o(almost_full_o), .count_o(count_o), .overflow_o(overflow_o),
        .underflow_o(underflow_o)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        for (int c = 0; c < CHANNELS; c++) begin
            mq[c].delete();
            m_dato[c] = '0;
            m_ov[c]   = 1'b0;
            m_un[c]   = 1'b0;
        end
    endtask

    // Applies one cycle of stimulus starting at a falling edge and returns at the next falling edge.
    task automatic drive(input logic [CHANNELS-1:0] pu, input logic [CHANNELS-1:0] po,
                         input logic [CHANNELS*WIDTH-1:0] d, input logic clr);
        push_i    = pu;
        pop_i     = po;
        dato_i    = d;
        clr_err_i = clr;
        for (int c = 0; c < CHANNELS; c++) begin
            int sz;
            logic ovh;
            logic unh;
            sz  = mq[c].size();
            ovh = 1'b0;
            unh = 1'b0;
            if (po[c]) begin
                if (sz == 0) unh = 1'b1;
                else m_dato[c] = mq[c].pop_front();
            end
            if (pu[c]) begin
                if (sz < DEPTH || po[c]) begin
                    mq[c].push_back(d[c*WIDTH +: WIDTH]);
                end else begin
                    ovh = 1'b1;
`ifdef FIFO_OVERWRITE_EN
                    void'(mq[c].pop_front());
                    mq[c].push_back(d[c*WIDTH +: WIDTH]);
`endif
                end
            end
            m_ov[c] = clr ? ovh : (m_ov[c] | ovh);
            m_un[c] = clr ? unh : (m_un[c] | unh);
        end
        @(posedge clk);
        @(negedge clk);
        push_i    = '0;
        pop_i     = '0;
        clr_err_i = 1'b0;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        @(negedge clk);
        model_reset();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; push_i = '0; pop_i = '0; dato_i = '0; clr_err_i = 1'b0;
        repeat (2) @(negedge clk);
        model_reset();
        checks++; if (count_o !== '0) begin errors++; $display("FAIL reset_count got %h expected 0", count_o); end
        checks++; if (empty_o !== 2'b11) begin errors++; $display("FAIL reset_empty got %b expected 11", empty_o); end
        checks++; if (full_o !== 2'b00 || almost_full_o !== 2'b00) begin errors++; $display("FAIL reset_full_af got %b/%b expected 00/00", full_o, almost_full_o); end
        checks++; if (dato_o !== '0) begin errors++; $display("FAIL reset_dato got %h expected 0", dato_o); end
        checks++; if (overflow_o !== 2'b00 || underflow_o !== 2'b00) begin errors++; $display("FAIL reset_err got %b/%b expected 00/00", overflow_o, underflow_o); end
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        apply_reset();
        drive(2'b01, 2'b00, 32'h0000_0006, 1'b0);
        checks++; if (count_o[3:0] !== 4'd1 || empty_o[0] !== 1'b0) begin errors++; $display("FAIL basic_push1 got cnt=%0d empty=%b expected 1/0", count_o[3:0], empty_o[0]); end
        drive(2'b01, 2'b00, 32'h0000_000A, 1'b0);
        checks++; if (count_o[3:0] !== 4'd2) begin errors++; $display("FAIL basic_push2 got cnt=%0d expected 2", count_o[3:0]); end
        drive(2'b00, 2'b01, '0, 1'b0);
        checks++; if (dato_o[15:0] !== 16'h6 || count_o[3:0] !== 4'd1) begin errors++; $display("FAIL basic_pop1 got dato=%h cnt=%0d expected 6/1", dato_o[15:0], count_o[3:0]); end
        drive(2'b00, 2'b01, '0, 1'b0);
        checks++; if (dato_o[15:0] !== 16'hA || count_o[3:0] !== 4'd0 || empty_o[0] !== 1'b1) begin errors++; $display("FAIL basic_pop2 got dato=%h cnt=%0d empty=%b expected a/0/1", dato_o[15:0], count_o[3:0], empty_o[0]); end
    endtask

    task automatic test_fill_overflow();
        logic [15:0] exp;
        apply_reset();
        for (int i = 1; i <= 8; i++) begin
            drive(2'b01, 2'b00, 32'(i), 1'b0);
            checks++;
            if (count_o[3:0] !== 4'(i) || almost_full_o[0] !== (i >= AF_LEVEL) || full_o[0] !== (i == DEPTH)) begin
                errors++; $display("FAIL fill_%0d got cnt=%0d af=%b full=%b", i, count_o[3:0], almost_full_o[0], full_o[0]);
            end
        end
        drive(2'b01, 2'b00, 32'h99, 1'b0);
        checks++; if (overflow_o !== 2'b01 || count_o[3:0] !== 4'd8) begin errors++; $display("FAIL ovf_flag got ovf=%b cnt=%0d expected 01/8", overflow_o, count_o[3:0]); end
        for (int i = 0; i < 8; i++) begin
`ifdef FIFO_OVERWRITE_EN
            exp = (i < 7) ? 16'(i + 2) : 16'h99;
`else
            exp = 16'(i + 1);
`endif
            drive(2'b00, 2'b01, '0, 1'b0);
            checks++; if (dato_o[15:0] !== exp) begin errors++; $display("FAIL drain_%0d got %h expected %h", i, dato_o[15:0], exp); end
        end
        checks++; if (empty_o[0] !== 1'b1 || overflow_o[0] !== 1'b1) begin errors++; $display("FAIL drain_end got empty=%b ovf=%b expected 1/1", empty_o[0], overflow_o[0]); end
    endtask

    task automatic test_push_pop_wrap();
        logic [15:0] exp;
        apply_reset();
        for (int i = 0; i < 3; i++) drive(2'b01, 2'b00, 32'(100 + i), 1'b0);
        for (int k = 0; k < 20; k++) begin
            drive(2'b01, 2'b01, 32'(103 + k), 1'b0);
            checks++;
            if (count_o[3:0] !== 4'd3 || dato_o[15:0] !== 16'(100 + k)) begin
                errors++; $display("FAIL wrap_%0d got cnt=%0d dato=%0d expected 3/%0d", k, count_o[3:0], dato_o[15:0], 100 + k);
            end
        end
        for (int i = 0; i < 5; i++) drive(2'b01, 2'b00, 32'(200 + i), 1'b0);
        for (int k = 0; k < 6; k++) begin
            exp = (k < 3) ? 16'(120 + k) : 16'(200 + k - 3);
            drive(2'b01, 2'b01, 32'(300 + k), 1'b0);
            checks++;
            if (count_o[3:0] !== 4'd8 || full_o[0] !== 1'b1 || overflow_o[0] !== 1'b0 || dato_o[15:0] !== exp) begin
                errors++; $display("FAIL full_pp_%0d got cnt=%0d full=%b ovf=%b dato=%0d expected 8/1/0/%0d", k, count_o[3:0], full_o[0], overflow_o[0], dato_o[15:0], exp);
            end
        end
    endtask

    task automatic test_underflow_clear();
        logic [15:0] lane0;
        drive(2'b10, 2'b00, 32'hBEEF_0000, 1'b0);
        drive(2'b00, 2'b10, '0, 1'b0);
        checks++; if (dato_o[31:16] !== 16'hBEEF) begin errors++; $display("FAIL ch1_pop got %h expected beef", dato_o[31:16]); end
        lane0 = dato_o[15:0];
        drive(2'b00, 2'b10, '0, 1'b0);
        checks++; if (underflow_o !== 2'b10) begin errors++; $display("FAIL udf_flag got %b expected 10", underflow_o); end
        checks++; if (dato_o[31:16] !== 16'hBEEF || dato_o[15:0] !== lane0 || count_o[3:0] !== 4'd8) begin
            errors++; $display("FAIL udf_hold got %h cnt0=%0d expected beef/%h/8", dato_o, count_o[3:0], lane0);
        end
        drive(2'b00, 2'b10, '0, 1'b1);
        checks++; if (underflow_o[1] !== 1'b1) begin errors++; $display("FAIL set_wins got %b expected 1", underflow_o[1]); end
        drive(2'b00, 2'b00, '0, 1'b1);
        checks++; if (underflow_o !== 2'b00 || overflow_o !== 2'b00) begin errors++; $display("FAIL clr_err got %b/%b expected 00/00", underflow_o, overflow_o); end
    endtask

    task automatic test_reset_midburst();
        apply_reset();
        for (int i = 0; i < 5; i++) drive(2'b11, 2'b00, {16'(i), 16'(50 + i)}, 1'b0);
        drive(2'b00, 2'b01, '0, 1'b0);
        drive(2'b00, 2'b10, '0, 1'b0);
        drive(2'b01, 2'b00, '0, 1'b0);
        checks++; if (count_o[3:0] !== 4'd5 || dato_o[15:0] !== 16'd50) begin errors++; $display("FAIL pre_rst got cnt=%0d dato=%0d expected 5/50", count_o[3:0], dato_o[15:0]); end
        push_i = 2'b11;
        pop_i  = 2'b00;
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (count_o !== '0 || empty_o !== 2'b11 || dato_o !== '0) begin errors++; $display("FAIL async_rst got cnt=%h empty=%b dato=%h expected 0/11/0", count_o, empty_o, dato_o); end
        checks++; if (full_o !== 2'b00 || almost_full_o !== 2'b00 || overflow_o !== 2'b00 || underflow_o !== 2'b00) begin
            errors++; $display("FAIL async_rst_flags got %b %b %b %b expected all 0", full_o, almost_full_o, overflow_o, underflow_o);
        end
        push_i = '0;
        @(negedge clk);
        model_reset();
        rst_n = 1'b1;
    endtask

    task automatic test_random();
        int pw;
        logic [CHANNELS-1:0] pu;
        logic [CHANNELS-1:0] po;
        for (int n = 0; n < 400; n++) begin
            pw = ((n / 40) % 2 == 0) ? 75 : 25;
            for (int c = 0; c < CHANNELS; c++) begin
                pu[c] = ($urandom_range(0, 99) < pw);
                po[c] = ($urandom_range(0, 99) < (100 - pw));
            end
            drive(pu, po, {16'($urandom), 16'($urandom)}, ($urandom_range(0, 15) == 0));
            for (int c = 0; c < CHANNELS; c++) begin
                checks++; if (count_o[c*CNT_W +: CNT_W] !== CNT_W'(mq[c].size())) begin errors++; $display("FAIL rnd_count ch%0d cyc%0d got %0d expected %0d", c, n, count_o[c*CNT_W +: CNT_W], mq[c].size()); end
                checks++; if (dato_o[c*WIDTH +: WIDTH] !== m_dato[c]) begin errors++; $display("FAIL rnd_dato ch%0d cyc%0d got %h expected %h", c, n, dato_o[c*WIDTH +: WIDTH], m_dato[c]); end
                checks++;
                if (full_o[c] !== (mq[c].size() == DEPTH) || empty_o[c] !== (mq[c].size() == 0) || almost_full_o[c] !== (mq[c].size() >= AF_LEVEL)) begin
                    errors++; $display("FAIL rnd_flags ch%0d cyc%0d got f=%b e=%b af=%b size=%0d", c, n, full_o[c], empty_o[c], almost_full_o[c], mq[c].size());
                end
                checks++; if (overflow_o[c] !== m_ov[c] || underflow_o[c] !== m_un[c]) begin errors++; $display("FAIL rnd_err ch%0d cyc%0d got %b/%b expected %b/%b", c, n, overflow_o[c], underflow_o[c], m_ov[c], m_un[c]); end
            end
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_basic();
        test_fill_overflow();
        test_push_pop_wrap();
        test_underflow_clear();
        test_reset_midburst();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
